id_ex_stage: RTL and testbench

ID/EX boundary stage of the 5-stage MIPS pipeline. It consumes the forwarding selects FWDA/FWDB from the forwarding unit, resolves rs/rt operands in ID, and detects load-use and mult/div-busy interlocks. It registers the resolved instruction into the E stage and inserts bubbles on stall or flush.

---
 rtl/id_ex_stage_pkg.sv | 36 +++
 rtl/id_ex_stage_md_busy_ctr.sv | 31 +++
 rtl/id_ex_stage.sv | 87 ++++++++
 tb/tb_id_ex_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline encodings for the ID/EX boundary.
// Forward selects, mult/div classes and control-bundle layout.
package id_ex_stage_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b11;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MUL  = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;
    localparam logic [1:0] MD_HILO = 2'b11;

    localparam int CTRL_W    = 16;
    localparam int CTRL_WREG = 0;
    localparam int CTRL_MEMW = 1;

    function automatic logic [31:0] fwd_mux(
        input logic [1:0]  sel,
        input logic [31:0] rf,
        input logic [31:0] e,
        input logic [31:0] m,
        input logic [31:0] w
    );
        logic [31:0] r;
        unique case (sel)
            FWD_RF: r = rf;
            FWD_E:  r = e;
            FWD_M:  r = m;
            FWD_W:  r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_ex_stage_md_busy_ctr.sv
// HI/LO busy counter: loads the unit latency on a mult/div capture,
// then counts down to zero.
module md_busy_ctr #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic start_mul,
    input  logic start_div,
    output logic busy
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (start_div)
            cnt <= CW'(DIV_CYCLES);
        else if (start_mul)
            cnt <= CW'(MULT_CYCLES);
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX boundary: operand forwarding, load-use and HI/LO interlocks,
// and the E-stage register with bubble insertion.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        FWDA,
    input  logic [1:0]        FWDB,
    input  logic [31:0]       rf_rs,
    input  logic [31:0]       rf_rt,
    input  logic [31:0]       E_result,
    input  logic [31:0]       M_result,
    input  logic [31:0]       W_result,
    input  logic              E_MemRead,
    input  logic              D_rs_used,
    input  logic              D_rt_used,
    input  logic [1:0]        D_md_op,
    input  logic [CTRL_W-1:0] D_ctrl,
    input  logic [4:0]        D_RD,
    input  logic [31:0]       D_imm,
    input  logic [31:0]       D_pc,
    input  logic              flush,
    output logic              stall,
    output logic              E_valid,
    output logic [31:0]       E_A,
    output logic [31:0]       E_B,
    output logic [CTRL_W-1:0] E_ctrl,
    output logic [4:0]        E_RD,
    output logic [31:0]       E_imm,
    output logic [31:0]       E_pc,
    output logic              md_busy
);

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        lu;
    logic        mdh;
    logic        cap;

    assign op_a = fwd_mux(FWDA, rf_rs, E_result, M_result, W_result);
    assign op_b = fwd_mux(FWDB, rf_rt, E_result, M_result, W_result);

    // A load in E cannot feed ID through the E path yet.
    assign lu = E_MemRead & E_valid
              & ((D_rs_used & (FWDA == FWD_E))
               | (D_rt_used & (FWDB == FWD_E)));

    assign mdh   = (D_md_op != MD_NONE) & md_busy;
    assign stall = (lu | mdh) & ~flush;
    assign cap   = ~(flush | stall);

    md_busy_ctr #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy_ctr (
        .clk      (clk),
        .rst      (rst),
        .start_mul(cap & (D_md_op == MD_MUL)),
        .start_div(cap & (D_md_op == MD_DIV)),
        .busy     (md_busy)
    );

    always_ff @(posedge clk) begin
        if (rst || !cap) begin
            E_valid <= 1'b0;
            E_A     <= '0;
            E_B     <= '0;
            E_ctrl  <= '0;
            E_RD    <= '0;
            E_imm   <= '0;
            E_pc    <= '0;
        end else begin
            E_valid <= 1'b1;
            E_A     <= op_a;
            E_B     <= op_b;
            E_ctrl  <= D_ctrl;
            E_RD    <= D_RD;
            E_imm   <= D_imm;
            E_pc    <= D_pc;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: cycle-level reference model
// plus directed scenarios with literal expectations.
module tb_id_ex_stage;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  FWDA, FWDB;
    logic [31:0] rf_rs, rf_rt;
    logic [31:0] E_result, M_result, W_result;
    logic        E_MemRead, D_rs_used, D_rt_used;
    logic [1:0]  D_md_op;
    logic [15:0] D_ctrl;
    logic [4:0]  D_RD;
    logic [31:0] D_imm, D_pc;
    logic        flush;
    logic        stall, E_valid, md_busy;
    logic [31:0] E_A, E_B, E_imm, E_pc;
    logic [15:0] E_ctrl;
    logic [4:0]  E_RD;

    id_ex_stage #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .FWDA(FWDA), .FWDB(FWDB),
        .rf_rs(rf_rs), .rf_rt(rf_rt), .E_result(E_result),
        .M_result(M_result), .W_result(W_result),
        .E_MemRead(E_MemRead), .D_rs_used(D_rs_used),
        .D_rt_used(D_rt_used), .D_md_op(D_md_op),
        .D_ctrl(D_ctrl), .D_RD(D_RD), .D_imm(D_imm),
        .D_pc(D_pc), .flush(flush), .stall(stall),
        .E_valid(E_valid), .E_A(E_A), .E_B(E_B),
        .E_ctrl(E_ctrl), .E_RD(E_RD), .E_imm(E_imm),
        .E_pc(E_pc), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: E contents plus "HI/LO busy until cycle N".
    bit          started = 0;
    int          cyc = 0;
    int          busy_until = 0;
    logic        m_valid;
    logic [31:0] m_a, m_b, m_imm, m_pc;
    logic [15:0] m_ctrl;
    logic [4:0]  m_rd;

    function automatic logic [31:0] pick(input logic [1:0] s,
                                         input logic [31:0] rf);
        if (s == 2'd0) return rf;
        if (s == 2'd1) return E_result;
        if (s == 2'd2) return M_result;
        return W_result;
    endfunction

    function automatic logic m_busy();
        return cyc < busy_until;
    endfunction

    function automatic logic m_stall();
        logic lu, mdh;
        lu = E_MemRead && m_valid
             && ((D_rs_used && FWDA == 2'd1)
              || (D_rt_used && FWDB == 2'd1));
        mdh = (D_md_op != 2'd0) && m_busy();
        return (lu || mdh) && !flush;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            busy_until = 0;
            {m_valid, m_a, m_b, m_ctrl, m_rd, m_imm, m_pc} = '0;
        end else if (started) begin
            if (flush || m_stall()) begin
                {m_valid, m_a, m_b, m_ctrl, m_rd, m_imm, m_pc} = '0;
            end else begin
                m_valid = 1'b1;
                m_a = pick(FWDA, rf_rs);
                m_b = pick(FWDB, rf_rt);
                m_ctrl = D_ctrl;
                m_rd = D_RD;
                m_imm = D_imm;
                m_pc = D_pc;
                if (D_md_op == 2'd1) busy_until = cyc + 1 + MC;
                if (D_md_op == 2'd2) busy_until = cyc + 1 + DC;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_stall", 32'(stall), 32'(m_stall()));
            chk("m_busy", 32'(md_busy), 32'(m_busy()));
            chk("m_valid", 32'(E_valid), 32'(m_valid));
            chk("m_A", E_A, m_a);
            chk("m_B", E_B, m_b);
            chk("m_ctrl", 32'(E_ctrl), 32'(m_ctrl));
            chk("m_RD", 32'(E_RD), 32'(m_rd));
            chk("m_imm", E_imm, m_imm);
            chk("m_pc", E_pc, m_pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] tab[4];
    int n;

    initial begin
        tab[0] = 32'hDEAD_BEEF;
        tab[1] = 32'h1111_1111;
        tab[2] = 32'h0000_1234;
        tab[3] = 32'h5555_5555;
        rst = 1'b1; FWDA = 2'd0; FWDB = 2'd0;
        rf_rs = tab[0]; rf_rt = tab[0];
        E_result = tab[1]; M_result = tab[2]; W_result = tab[3];
        E_MemRead = 1'b0; D_rs_used = 1'b0; D_rt_used = 1'b0;
        D_md_op = 2'd0; D_ctrl = 16'h0001; D_RD = 5'd0;
        D_imm = 32'h0000_00AA; D_pc = 32'h0040_0000;
        flush = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(E_valid), 32'd0);
        chk("rst_busy", 32'(md_busy), 32'd0);
        rst = 1'b0;

        // forwarding, every select code on both operands
        for (int f = 0; f < 4; f++) begin
            FWDA = 2'(f);
            FWDB = 2'(3 - f);
            D_RD = 5'(f + 1);
            D_pc = 32'h0040_0000 + 32'(4 * f);
            tick();
            chk("fwd_A", E_A, tab[f]);
            chk("fwd_B", E_B, tab[3 - f]);
            chk("fwd_valid", 32'(E_valid), 32'd1);
        end

        // load-use on rt
        FWDA = 2'd0; FWDB = 2'd1;
        E_MemRead = 1'b1; D_rt_used = 1'b1; D_ctrl = 16'h0003;
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_bubble_ctrl", 32'(E_ctrl), 32'd0);
        chk("lu_bubble_valid", 32'(E_valid), 32'd0);
        E_MemRead = 1'b0; FWDB = 2'd2;
        #1;
        chk("lu_release", 32'(stall), 32'd0);
        tick();
        chk("lu_cap_B", E_B, 32'h0000_1234);
        chk("lu_cap_ctrl", 32'(E_ctrl), 32'h0003);

        // same pattern, rt not read
        E_MemRead = 1'b1; FWDB = 2'd1; D_rt_used = 1'b0;
        #1;
        chk("nolu_stall", 32'(stall), 32'd0);
        tick();
        chk("nolu_valid", 32'(E_valid), 32'd1);
        E_MemRead = 1'b0; FWDB = 2'd0;

        // mult then mfhi; then div then mfhi
        for (int k = 0; k < 2; k++) begin
            D_md_op = (k == 0) ? 2'd1 : 2'd2;
            tick();
            D_md_op = 2'd3;
            #1;
            n = 0;
            for (int i = 0; i < 30; i++) begin
                if (!stall) break;
                n++;
                tick();
            end
            chk(k == 0 ? "mul_stalls" : "div_stalls", n,
                k == 0 ? 32'd5 : 32'd10);
            tick();
            chk("md_cap_valid", 32'(E_valid), 32'd1);
            chk("md_cap_busy", 32'(md_busy), 32'd0);
            D_md_op = 2'd0;
        end

        // flush overrides a load-use hazard, counter keeps running
        D_md_op = 2'd1;
        tick();
        D_md_op = 2'd0;
        E_MemRead = 1'b1; FWDA = 2'd1; D_rs_used = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_stall", 32'(stall), 32'd0);
        tick();
        chk("flush_valid", 32'(E_valid), 32'd0);
        chk("flush_ctrl", 32'(E_ctrl), 32'd0);
        flush = 1'b0; E_MemRead = 1'b0; D_rs_used = 1'b0;
        FWDA = 2'd0;
        #1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (!md_busy) break;
            n++;
            tick();
        end
        chk("flush_busy_left", n, 32'd4);

        // reset during a div countdown at cnt=7
        D_md_op = 2'd2;
        tick();
        D_md_op = 2'd3;
        tick(); tick(); tick();
        chk("pre_rst_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        chk("rst_E_A", E_A, 32'd0);
        chk("rst_E_pc", E_pc, 32'd0);
        rst = 1'b0; D_md_op = 2'd0;
        tick();
        chk("post_rst_valid", 32'(E_valid), 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
